// File: rtl/rf_write_buffer.sv
// In-order write-back FIFO in front of the register file, with two youngest-match forwarding lookups.
// Entries reach rf_W one cycle after acceptance at the earliest; in_ready drops when full, rf_hold stalls the drain.
module rf_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_reg,
    input  logic [DW-1:0] in_data,
    input  logic          rf_hold,
    output logic          rf_W,
    output logic [AW-1:0] rf_W_reg,
    output logic [DW-1:0] rf_W_data,
    input  logic [AW-1:0] lk_reg1,
    output logic          lk_hit1,
    output logic [DW-1:0] lk_data1,
    input  logic [AW-1:0] lk_reg2,
    output logic          lk_hit2,
    output logic [DW-1:0] lk_data2,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] r_reg  [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Writes to register 0 complete the handshake but are dropped here.
    assign w_push = in_valid && !w_full && (in_reg != '0);
    assign w_pop  = !w_empty && !rf_hold;

    assign in_ready  = !w_full;
    assign rf_W      = w_pop;
    assign rf_W_reg  = r_reg[r_head];
    assign rf_W_data = r_data[r_head];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_reg[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_reg[r_tail]  <= in_reg;
                r_data[r_tail] <= in_data;
                r_tail         <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk oldest to youngest so the last match wins; the head is included even while it drains.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] key);
        logic [DW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_reg[idx] == key) && (key != '0)) begin
                res = {1'b1, r_data[idx]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {lk_hit1, lk_data1} = lookup(lk_reg1);
        {lk_hit2, lk_data2} = lookup(lk_reg2);
    end

endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed and random stimulus for rf_write_buffer; a queue scoreboard predicts every commit and lookup.
module tb_rf_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_reg = '0;
    logic [DW-1:0] in_data = '0;
    logic          rf_hold = 1'b0;
    logic          rf_W;
    logic [AW-1:0] rf_W_reg;
    logic [DW-1:0] rf_W_data;
    logic [AW-1:0] lk_reg1 = '0;
    logic          lk_hit1;
    logic [DW-1:0] lk_data1;
    logic [AW-1:0] lk_reg2 = '0;
    logic          lk_hit2;
    logic [DW-1:0] lk_data2;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;
    ent_t sb[$];

    rf_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .rf_hold(rf_hold), .rf_W(rf_W), .rf_W_reg(rf_W_reg), .rf_W_data(rf_W_data),
        .lk_reg1(lk_reg1), .lk_hit1(lk_hit1), .lk_data1(lk_data1),
        .lk_reg2(lk_reg2), .lk_hit2(lk_hit2), .lk_data2(lk_data2),
        .count(count), .empty(empty), .full(full)
    );

    initial forever #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW:0] model_lookup(input logic [AW-1:0] key);
        logic [DW:0] res;
        res = '0;
        foreach (sb[i]) begin
            if (key != '0 && sb[i].r == key) res = {1'b1, sb[i].d};
        end
        return res;
    endfunction

    // Scoreboard: checks current outputs against the queue, then applies the coming edge's push/pop.
    always @(negedge CLK) begin
        logic          m_push;
        logic          m_pop;
        logic [DW:0]   l1;
        logic [DW:0]   l2;
        ent_t          e;
        if (RST) begin
            sb.delete();
        end else begin
            m_pop  = (sb.size() != 0) && !rf_hold;
            m_push = in_valid && (sb.size() != DEPTH) && (in_reg != '0);
            l1 = model_lookup(lk_reg1);
            l2 = model_lookup(lk_reg2);
            chk("mon_count", 64'(count), 64'(sb.size()));
            chk("mon_in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
            chk("mon_rf_W", 64'(rf_W), 64'(m_pop));
            chk("mon_lk1", 64'({lk_hit1, lk_data1}), 64'(l1));
            chk("mon_lk2", 64'({lk_hit2, lk_data2}), 64'(l2));
            if (m_pop) begin
                e = sb.pop_front();
                chk("mon_commit_reg", 64'(rf_W_reg), 64'(e.r));
                chk("mon_commit_data", 64'(rf_W_data), 64'(e.d));
            end
            if (m_push) begin
                e.r = in_reg;
                e.d = in_data;
                sb.push_back(e);
            end
        end
    end

    initial begin
        // Reset state
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_rf_W", 64'(rf_W), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_lk1", 64'({lk_hit1, lk_data1}), 64'd0);
        chk("rst_lk2", 64'({lk_hit2, lk_data2}), 64'd0);
        RST = 1'b0;

        // Single write, one-cycle latency
        in_valid = 1'b1; in_reg = 5'd5; in_data = 32'h11;
        #1 chk("t1_no_bypass", 64'(rf_W), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("t1_rf_W", 64'(rf_W), 64'd1);
        chk("t1_reg", 64'(rf_W_reg), 64'd5);
        chk("t1_data", 64'(rf_W_data), 64'h11);
        tick();
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_rf_W_off", 64'(rf_W), 64'd0);

        // Fill under hold, then drain in order
        rf_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_reg = AW'(i); in_data = 32'hA0 + 32'(i);
            tick();
        end
        in_reg = 5'd9; in_data = 32'hBAD;
        chk("t2_full", 64'(full), 64'd1);
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        chk("t2_count", 64'(count), 64'd4);
        tick();
        chk("t2_no_overflow", 64'(count), 64'd4);
        in_valid = 1'b0; rf_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1 chk("t2_drain_we", 64'(rf_W), 64'd1);
            chk("t2_drain_reg", 64'(rf_W_reg), 64'(i));
            chk("t2_drain_data", 64'(rf_W_data), 64'hA0 + 64'(i));
            chk("t2_drain_count", 64'(count), 64'(5 - i));
            tick();
        end
        chk("t2_count_zero", 64'(count), 64'd0);

        // Forwarding: youngest match wins
        rf_hold = 1'b1;
        in_valid = 1'b1; in_reg = 5'd7; in_data = 32'h100; tick();
        in_reg = 5'd7; in_data = 32'h200; tick();
        in_reg = 5'd8; in_data = 32'h300; tick();
        in_valid = 1'b0; lk_reg1 = 5'd7; lk_reg2 = 5'd9;
        #1 chk("t3_hit1", 64'(lk_hit1), 64'd1);
        chk("t3_data1", 64'(lk_data1), 64'h200);
        chk("t3_hit2", 64'(lk_hit2), 64'd0);
        chk("t3_data2", 64'(lk_data2), 64'd0);
        lk_reg2 = 5'd8;
        #1 chk("t3_lk8", 64'({lk_hit2, lk_data2}), {31'd0, 1'b1, 32'h300});
        rf_hold = 1'b0;
        tick();
        rf_hold = 1'b1;
        #1 chk("t3_after_drain", 64'({lk_hit1, lk_data1}), {31'd0, 1'b1, 32'h200});
        chk("t3_count", 64'(count), 64'd2);
        rf_hold = 1'b0;
        tick(); tick();
        chk("t3_empty", 64'(empty), 64'd1);
        chk("t3_popped_gone", 64'(lk_hit1), 64'd0);

        // Register 0 writes are consumed but dropped
        in_valid = 1'b1; in_reg = 5'd0; in_data = 32'hDEAD; lk_reg1 = 5'd0;
        #1 chk("t4_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_rf_W", 64'(rf_W), 64'd0);
        chk("t4_lk0", 64'(lk_hit1), 64'd0);

        // Full with drain: pop without push, then streaming through the wrapping ring
        rf_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_reg = AW'(10 + i); in_data = 32'hC0 + 32'(i);
            tick();
        end
        rf_hold = 1'b0; in_reg = 5'd20; in_data = 32'hD00;
        #1 chk("t5_ready_full", 64'(in_ready), 64'd0);
        chk("t5_pop_full", 64'(rf_W), 64'd1);
        tick();
        chk("t5_count3", 64'(count), 64'd3);
        chk("t5_ready", 64'(in_ready), 64'd1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            in_reg = AW'(16 + (k % 8)); in_data = 32'hD00 + 32'(k);
            chk("t5_stream_count", 64'(count), 64'd3);
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("t5_drained", 64'(empty), 64'd1);

        // Random traffic with register collisions
        for (int k = 0; k < 200; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_reg   = AW'($urandom_range(0, 7));
            in_data  = $urandom;
            rf_hold  = ($urandom_range(0, 3) == 0);
            lk_reg1  = AW'($urandom_range(0, 7));
            lk_reg2  = AW'($urandom_range(0, 7));
            tick();
        end
        in_valid = 1'b0; rf_hold = 1'b0;
        repeat (DEPTH + 1) tick();
        chk("rnd_drained", 64'(count), 64'd0);

        // Asynchronous reset mid-drain
        rf_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_reg = AW'(1 + i); in_data = 32'hE0 + 32'(i);
            tick();
        end
        in_valid = 1'b0; rf_hold = 1'b0; lk_reg1 = 5'd3;
        tick();
        chk("t6_pre_count", 64'(count), 64'd3);
        #2 RST = 1'b1;
        #1 chk("t6_count", 64'(count), 64'd0);
        chk("t6_rf_W", 64'(rf_W), 64'd0);
        chk("t6_empty", 64'(empty), 64'd1);
        chk("t6_lk", 64'({lk_hit1, lk_data1}), 64'd0);
        tick();
        RST = 1'b0;
        in_valid = 1'b1; in_reg = 5'd6; in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        chk("t6_post_we", 64'(rf_W), 64'd1);
        chk("t6_post_reg", 64'(rf_W_reg), 64'd6);
        chk("t6_post_data", 64'(rf_W_data), 64'h55);
        tick();
        chk("t6_post_empty", 64'(empty), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_write_buffer.md
Name: rf_write_buffer

Overview:
- Write-side front end for the CPU register file.
- Accepts register write-back requests (destination index + data) into a small in-order FIFO.
- Drains one entry per cycle into the register file write port (W / W_reg / W_data) unless held.
- Provides forwarding lookups so readers see the youngest pending value for a register not yet committed.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, at least 2.
- AW, 5, register index width.
- DW, 32, data width.
- CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  write-back request present.
- in_ready  output  1  buffer can accept a request; equals !full.
- in_reg  input  AW  destination register index.
- in_data  input  DW  write data.
- rf_hold  input  1  1 = register file must not be written this cycle (drain stall).
- rf_W  output  1  write enable to the register file.
- rf_W_reg  output  AW  register file write index.
- rf_W_data  output  DW  register file write data.
- lk_reg1  input  AW  forwarding lookup index, port 1.
- lk_hit1  output  1  port 1 has a pending entry for lk_reg1.
- lk_data1  output  DW  youngest pending data for lk_reg1.
- lk_reg2  input  AW  forwarding lookup index, port 2.
- lk_hit2  output  1  port 2 has a pending entry for lk_reg2.
- lk_data2  output  DW  youngest pending data for lk_reg2.
- count  output  CW  current occupancy, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- State: DEPTH x {reg, data} storage, head pointer, tail pointer, count. Pointers wrap modulo DEPTH.
- Reset (asynchronous, any time): head = tail = 0, count = 0. Pending entries are discarded and storage contents are don't-care. Outputs: in_ready = 1, empty = 1, full = 0, rf_W = 0, lk_hit1/2 = 0, lk_data1/2 = 0.
- Accept: push = in_valid && in_ready && (in_reg != 0). Writes to register 0 are consumed (handshake completes) but never stored.
- Drain, combinational from head:
  - rf_W = !empty && !rf_hold; rf_W_reg = head reg; rf_W_data = head data.
  - When empty or held, rf_W = 0 and rf_W_reg / rf_W_data hold the stale head values.
  - pop = rf_W. The head advances on the same edge the register file captures the write.
- Latency: an entry pushed at edge N is visible on rf_W in cycle N+1 at the earliest (empty buffer, no hold). There is no same-cycle bypass from in_* to rf_*.
- Count updates: push only, +1; pop only, -1; push and pop together, unchanged.
- Full: in_ready = 0, even if a pop occurs in the same cycle; no push is possible.
- Empty: no pop. rf_hold has no effect.
- Ordering: strict FIFO. Multiple pending writes to the same register commit oldest first.
- Forwarding, combinational:
  - lk_hitK = 1 if any valid entry (head up to tail-1, including the head being written this cycle) has reg == lk_regK and lk_regK != 0.
  - lk_dataK = data of the youngest matching entry (nearest tail); 0 when there is no hit.
  - The incoming in_* request is not included in the lookup.
- An entry popped at edge N is no longer reported by lookups after edge N. The register file now holds that value.

Test Plan:
- Reset, then push {reg 5, 0x11} -> next cycle rf_W=1, rf_W_reg=5, rf_W_data=0x11; following cycle empty=1, rf_W=0.
- rf_hold=1; push regs 1,2,3,4 with data 0xA1..0xA4 -> full=1, in_ready=0, count=4; 5th request stays unaccepted. Release hold -> commits in order 1,2,3,4 on consecutive cycles, count 4→0.
- Hold; push {7,0x100}, {7,0x200}, {8,0x300} -> lk_reg1=7 gives hit=1, data=0x200; lk_reg2=9 gives hit=0, data=0. After releasing hold and letting one entry drain, lk_reg1=7 still returns 0x200.
- Push {0, 0xDEAD} -> in_ready handshake completes, count stays 0, rf_W never asserts, lk_reg=0 gives hit=0.
- Full with hold=0, in_valid=1 -> pop occurs and count drops to 3; the new request is taken the next cycle. Verify no overflow and tail wrap-around over 3+ full cycles.
- Assert RST mid-drain with count=3 -> count=0 and rf_W=0 immediately (asynchronous). After release, a push of {6,0x55} commits normally.
